// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: one word access per request with byte lanes, sign/zero-extended loads.
// Optional feature macro: LSU_TIMEOUT_EN (bounds the WAIT state to TIMEOUT_CYCLES cycles).
module lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    output logic        mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("lsu: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, STRB, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt_q, cnt_d;
`endif

    logic        f3_legal;
    logic        misaligned;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        mem_done;

    // Request decode works straight off the request inputs, only used on the acceptance edge.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        lane_mask  = 4'b1111;
        lane_wdata = req_wdata;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !req_we;
            default:                f3_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                lane_mask  = 4'b0011 << {req_addr[1], 1'b0};
                lane_wdata = {2{req_wdata[15:0]}};
            end
            default: misaligned = |req_addr[1:0];
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    assign mem_done = we_q ? !mem_wbusy : !mem_rbusy;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    rdata_d = 32'h0;
                    if (!f3_legal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = {req_addr[31:2], 2'b00};
                        wmask_d = req_we ? lane_mask : 4'b0000;
                        wdata_d = req_we ? lane_wdata : 32'h0;
                        state_d = STRB;
                    end
                end
            end
            // Busy is deliberately not looked at here: it may still be low from the previous access.
            STRB: begin
                state_d = WAIT;
`ifdef LSU_TIMEOUT_EN
                cnt_d   = 8'h0;
`endif
            end
            WAIT: begin
                if (mem_done) begin
                    if (!we_q) begin
                        rdata_d = ld_ext;
                    end
                    state_d = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            addr_q  <= 32'h0;
            wmask_q <= 4'h0;
            wdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign mem_rstrb  = (state_q == STRB) & !we_q;
    assign mem_wstrb  = (state_q == STRB) & we_q;
    assign mem_addr   = addr_q;
    assign mem_wmask  = wmask_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic        mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_rstrb  (mem_rstrb),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rbusy  (mem_rbusy),
        .mem_wbusy  (mem_wbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request before the edge, then scramble the inputs once it has been taken.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input int extra, input logic [31:0] exp);
        mem_rbusy = 1'b0;
        mem_rdata = JUNK;
        issue(1'b0, f3, addr, 32'h0);
        @(negedge clk);
        check({tag, " rstrb c1"}, mem_rstrb, 1);
        check({tag, " wstrb c1"}, mem_wstrb, 0);
        check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, " wmask"}, mem_wmask, 0);
        check({tag, " ready c1"}, req_ready, 0);
        @(negedge clk);
        check({tag, " rstrb c2"}, mem_rstrb, 0);
        check({tag, " rvalid c2"}, resp_valid, 0);
        mem_rbusy = (extra != 0);
        mem_rdata = (extra != 0) ? JUNK : word;
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            check({tag, " rvalid busy"}, resp_valid, 0);
            if (i == extra - 1) begin
                mem_rbusy = 1'b0;
                mem_rdata = word;
            end
        end
        @(negedge clk);
        check({tag, " rvalid"}, resp_valid, 1);
        check({tag, " rdata"}, resp_rdata, exp);
        check({tag, " err"}, resp_err, 0);
        check({tag, " addr held"}, mem_addr, {addr[31:2], 2'b00});
        mem_rdata = JUNK;
        @(negedge clk);
        check({tag, " rvalid after"}, resp_valid, 0);
        check({tag, " rdata after"}, resp_rdata, 0);
        check({tag, " ready after"}, req_ready, 1);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int extra,
                             input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
        mem_wbusy = 1'b0;
        issue(1'b1, f3, addr, wdata);
        @(negedge clk);
        check({tag, " wstrb c1"}, mem_wstrb, 1);
        check({tag, " rstrb c1"}, mem_rstrb, 0);
        check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, " wmask"}, mem_wmask, exp_mask);
        check({tag, " wdata"}, mem_wdata, exp_wdata);
        @(negedge clk);
        check({tag, " wstrb c2"}, mem_wstrb, 0);
        check({tag, " rvalid c2"}, resp_valid, 0);
        mem_wbusy = (extra != 0);
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            check({tag, " rvalid busy"}, resp_valid, 0);
            check({tag, " wdata held"}, mem_wdata, exp_wdata);
            if (i == extra - 1) mem_wbusy = 1'b0;
        end
        @(negedge clk);
        check({tag, " rvalid"}, resp_valid, 1);
        check({tag, " err"}, resp_err, 0);
        check({tag, " rdata"}, resp_rdata, 0);
        @(negedge clk);
        check({tag, " rvalid after"}, resp_valid, 0);
    endtask

    task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        mem_rbusy = 1'b0;
        mem_wbusy = 1'b0;
        issue(we, f3, addr, 32'h1234_5678);
        @(negedge clk);
        check({tag, " rvalid"}, resp_valid, 1);
        check({tag, " err"}, resp_err, 1);
        check({tag, " rdata"}, resp_rdata, 0);
        check({tag, " strobes"}, {mem_rstrb, mem_wstrb}, 0);
        @(negedge clk);
        check({tag, " rvalid after"}, resp_valid, 0);
        check({tag, " strobes after"}, {mem_rstrb, mem_wstrb}, 0);
        check({tag, " ready after"}, req_ready, 1);
    endtask

    initial begin
        logic saw_resp;
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'h0;
        mem_rdata  = JUNK;
        mem_rbusy  = 1'b1;
        mem_wbusy  = 1'b1;

        repeat (2) @(negedge clk);
        check("reset ready", req_ready, 1);
        check("reset rvalid", resp_valid, 0);
        check("reset rstrb", mem_rstrb, 0);
        check("reset wstrb", mem_wstrb, 0);
        check("reset addr", mem_addr, 0);
        check("reset wmask", mem_wmask, 0);
        check("reset wdata", mem_wdata, 0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        run_load("lw 0x10", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        run_load("lb 0x13", 3'b000, 32'h0000_0013, 32'h80FF_0000, 0, 32'hFFFF_FF80);
        run_load("lbu 0x13", 3'b100, 32'h0000_0013, 32'h80FF_0000, 0, 32'h0000_0080);
        run_load("lb 0x12", 3'b000, 32'h0000_0012, 32'h80FF_0000, 0, 32'hFFFF_FFFF);
        run_load("lb 0x11", 3'b000, 32'h0000_0011, 32'h80FF_0000, 0, 32'h0000_0000);
        run_load("lh 0x12", 3'b001, 32'h0000_0012, 32'h80FF_0000, 0, 32'hFFFF_80FF);
        run_load("lhu 0x12", 3'b101, 32'h0000_0012, 32'h80FF_0000, 0, 32'h0000_80FF);
        run_load("lh 0x10", 3'b001, 32'h0000_0010, 32'h1234_8001, 0, 32'hFFFF_8001);
        run_load("lw b2b1", 3'b010, 32'h0000_0100, 32'h0102_0304, 0, 32'h0102_0304);
        run_load("lw b2b2", 3'b010, 32'h0000_0104, 32'hA5A5_5A5A, 5, 32'hA5A5_5A5A);

        run_store("sh 0x22", 3'b001, 32'h0000_0022, 32'h0000_1234, 0, 4'b1100, 32'h1234_1234);
        run_store("sh 0x20", 3'b001, 32'h0000_0020, 32'h5555_BEEF, 0, 4'b0011, 32'hBEEF_BEEF);
        run_store("sb 0x31", 3'b000, 32'h0000_0031, 32'hDEAD_BEAB, 0, 4'b0010, 32'hABAB_ABAB);
        run_store("sb 0x33", 3'b000, 32'h0000_0033, 32'h0000_0077, 0, 4'b1000, 32'h7777_7777);
        run_store("sw 0x44", 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 2, 4'b1111, 32'hCAFE_F00D);

        run_err("lw 0x06", 1'b0, 3'b010, 32'h0000_0006);
        run_err("st f3=011", 1'b1, 3'b011, 32'h0000_0008);
        run_err("lh 0x11", 1'b0, 3'b001, 32'h0000_0011);
        run_err("sh 0x23", 1'b1, 3'b001, 32'h0000_0023);
        run_err("sw 0x02", 1'b1, 3'b010, 32'h0000_0002);
        run_err("ld f3=110", 1'b0, 3'b110, 32'h0000_0000);
        run_err("st f3=100", 1'b1, 3'b100, 32'h0000_0000);

`ifdef LSU_TIMEOUT_EN
        mem_rbusy = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        @(negedge clk);
        mem_rbusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("timeout pending", resp_valid, 0);
        end
        @(negedge clk);
        check("timeout rvalid", resp_valid, 1);
        check("timeout err", resp_err, 1);
        check("timeout rdata", resp_rdata, 0);
        @(negedge clk);
`endif

        // Reset while the strobe is up: it must drop at once.
        mem_rbusy = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        @(negedge clk);
        check("rst strb rstrb before", mem_rstrb, 1);
        rst = 1'b0;
        #1;
        check("rst strb rstrb", mem_rstrb, 0);
        check("rst strb addr", mem_addr, 0);
        check("rst strb ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // Reset in WAIT: no response afterwards.
        mem_rbusy = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0304, 32'h0);
        @(negedge clk);
        mem_rbusy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst wait rvalid", resp_valid, 0);
        check("rst wait addr", mem_addr, 0);
        check("rst wait ready", req_ready, 1);
        mem_rbusy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        saw_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            saw_resp = saw_resp | resp_valid;
        end
        check("rst wait no resp", saw_resp, 0);

        run_load("lw after rst", 3'b010, 32'h0000_0308, 32'h5A5A_A5A5, 1, 32'h5A5A_A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
